// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   rx_state_e : receive FSM states
//   OVERSAMPLE : oversample ticks per bit
//   MID_TICK   : tick index that lands on the middle of the start bit
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead receive FIFO.
//   clk_clk, reset_reset : clock, synchronous active-high reset
//   wr_en, wr_data       : push request and byte
//   rd_ready             : consumer accepts head byte (pop when rd_valid && rd_ready)
//   rd_data, rd_valid    : head byte, FIFO not empty
//   level                : occupancy 0..DEPTH
//   overrun              : one-cycle pulse when a push is dropped because the FIFO is full
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_ok;

  assign full     = (level == (AW+1)'(DEPTH));
  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_ok    = wr_en && (!full || pop);
  assign rd_data  = mem[rd_ptr];

  // NOTE: storage has no reset; rd_data is only meaningful while rd_valid is high,
  // and leaving the array unreset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      overrun <= wr_en && full && !pop;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 16x oversample tick generator, receive FSM
// and a show-ahead byte FIFO.
//   clk_clk      : single clock (CLK_HZ)
//   reset_reset  : synchronous active-high reset
//   rx_i         : asynchronous serial line, idles high
//   rx_data      : head-of-FIFO byte, valid while rx_valid
//   rx_valid     : FIFO not empty
//   rx_ready     : consumer accepts head byte
//   fifo_level   : FIFO occupancy
//   frame_err, overrun, parity_err : one-cycle error pulses
// Build option: define UART_RX_PARITY_EN for 8E1 frames; default is 8N1 and
// parity_err is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             rx_meta, rx_s;
  logic [1:0]       sync_fill;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, div_clr;

  rx_state_e  state, state_nx;
  logic [3:0] tick_cnt, tick_cnt_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       line_high, line_high_nx;
  logic       frame_err_nx;
  logic       push;
  logic       bit_end;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nx;
  logic parity_err_nx;
`endif

  // Synchronizer resets to the idle level. sync_fill marks when rx_s holds a
  // real sample of the line rather than the reset value.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= rx_i;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  assign tick    = (div_cnt == DIV_W'(DIV - 1));
  assign bit_end = tick && (tick_cnt == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      line_high <= 1'b0;
      div_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      line_high <= line_high_nx;
      div_cnt   <= (div_clr || tick) ? '0 : div_cnt + DIV_W'(1);
      frame_err <= frame_err_nx;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nx;
      parity_err <= parity_err_nx;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    tick_cnt_nx  = tick_cnt;
    bit_cnt_nx   = bit_cnt;
    shreg_nx     = shreg;
    // A start is only accepted once the line has genuinely been seen high:
    // this gives break tolerance after a framing error and after reset.
    line_high_nx = line_high | (sync_fill[1] & rx_s);
    div_clr      = 1'b0;
    push         = 1'b0;
    frame_err_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx    = par_bad;
    parity_err_nx = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (line_high && !rx_s) begin
          state_nx     = START;
          tick_cnt_nx  = '0;
          div_clr      = 1'b1;  // align oversample ticks to the falling edge
          line_high_nx = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt == 4'(MID_TICK)) begin
            tick_cnt_nx = '0;
            bit_cnt_nx  = '0;
            state_nx    = rx_s ? IDLE : DATA;  // high at mid-bit: glitch, not a start
          end else begin
            tick_cnt_nx = tick_cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (bit_end) begin
          tick_cnt_nx = '0;
          shreg_nx    = {rx_s, shreg[7:1]};  // LSB arrives first
          bit_cnt_nx  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end else if (tick) begin
          tick_cnt_nx = tick_cnt + 4'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tick_cnt_nx   = '0;
          par_bad_nx    = (^shreg) ^ rx_s;  // even parity: data ^ parity must be 0
          parity_err_nx = (^shreg) ^ rx_s;
          state_nx      = STOP;
        end else if (tick) begin
          tick_cnt_nx = tick_cnt + 4'd1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          tick_cnt_nx = '0;
          state_nx    = IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
          end else begin
            frame_err_nx = 1'b1;
            line_high_nx = 1'b0;
          end
        end else if (tick) begin
          tick_cnt_nx = tick_cnt + 4'd1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .wr_en      (push),
    .wr_data    (shreg),
    .rd_ready   (rx_ready),
    .rd_data    (rx_data),
    .rd_valid   (rx_valid),
    .level      (fifo_level),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default parameters (one bit = 432 clocks).
// Stimulus pushes expected bytes into exp_q; the monitor pops and compares
// whenever a byte is handed over (rx_valid && rx_ready) and counts error pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CYC = 432;
  localparam int HALF    = BIT_CYC / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] fifo_level;
  logic       frame_err, overrun, parity_err;

  uart_rx dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .rx_i       (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         pop_cnt = 0;
  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int         cyc = 0;
  int         valid_seen_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
    if (rx_valid && valid_seen_cyc < 0) valid_seen_cyc = cyc;
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: actual 0x%0h required no byte", rx_data);
      end else begin
        check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
      end
      pop_cnt++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    rx = 1'b0;
    step(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(BIT_CYC);
    end
    if (use_par) begin
      rx = par_bit;
      step(BIT_CYC);
    end
    rx = stop_bit;
    step(BIT_CYC);
    rx = 1'b1;
  endtask

  // Good frame; expect says whether the byte should reach the consumer.
  task automatic send_byte(input logic [7:0] d, input bit expect_it);
    if (expect_it) exp_q.push_back(d);
    send_frame(d, 1'b1, PAR_EN, ^d);
    step(8);
  endtask

  task automatic wait_pops(input int target, input string name);
    int n = 0;
    while (pop_cnt < target && n < 1000) begin
      step();
      n++;
    end
    check(name, pop_cnt, target);
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, fe0, pops;

    // Reset state
    step(5);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_fifo_level", int'(fifo_level), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    rst = 1'b0;
    step(10);

    // 0xA5: data, latency of rx_valid against mid stop bit (4104) + sync/edge latency
    t0 = cyc;
    valid_seen_cyc = -1;
    send_byte(8'hA5, 1'b1);
    wait_pops(1, "a5_pop_count");
    check_range("a5_valid_latency", valid_seen_cyc - t0, 4104, 4112);
    check("a5_frame_err", fe_cnt, 0);

    // 100-cycle low glitch: rejected at mid start bit
    rx = 1'b0;
    step(100);
    rx = 1'b1;
    step(500);
    check("glitch_level", int'(fifo_level), 0);
    check("glitch_state", int'(dut.state), int'(IDLE));
    check("glitch_pops", pop_cnt, 1);

    // 0x3C with bad stop bit, then 0x3D
    send_frame(8'h3C, 1'b0, PAR_EN, ^8'h3C);
    step(20);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_level", int'(fifo_level), 0);
    send_byte(8'h3D, 1'b1);
    wait_pops(2, "after_ferr_pop_count");

    // Overrun: consumer stalled, 9 bytes into an 8-deep FIFO
    step();
    rx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    check("full_level", int'(fifo_level), 8);
    check("full_no_overrun", ov_cnt, 0);
    send_byte(8'h09, 1'b0);
    check("overrun_pulses", ov_cnt, 1);
    check("overrun_level", int'(fifo_level), 8);
    rx_ready = 1'b1;
    wait_pops(10, "drain_pop_count");
    check("drain_level", int'(fifo_level), 0);

    // Reset during data bit 4 of 0x5A, then a clean 0x5A
    fe0 = fe_cnt;
    rx = 1'b0;
    step(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rx = logic'((8'h5A >> i) & 8'h01);
      step(BIT_CYC);
    end
    rx = 1'b1;  // bit 4 of 0x5A
    step(HALF);
    rst = 1'b1;
    step(3);
    check("mid_rst_rx_valid", int'(rx_valid), 0);
    check("mid_rst_level", int'(fifo_level), 0);
    check("mid_rst_frame_err", int'(frame_err), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_parity_err", int'(parity_err), 0);
    check("mid_rst_state", int'(dut.state), int'(IDLE));
    rst = 1'b0;
    step(2 * BIT_CYC);
    check("mid_rst_no_push", pop_cnt, 10);
    send_byte(8'h5A, 1'b1);
    wait_pops(11, "after_rst_pop_count");
    check("after_rst_frame_err", fe_cnt, fe0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    step(20);
    check("parity_err_pulses", pe_cnt, 1);
    check("parity_bad_level", int'(fifo_level), 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    step(8);
    wait_pops(12, "parity_good_pop_count");
    check("parity_good_no_err", pe_cnt, 1);
`else
    check("parity_err_never", pe_cnt, 0);
`endif

    pops = 0;
    while (exp_q.size() != 0 && pops < 1000) begin
      step();
      pops++;
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the clk_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning receive buffer depth in bytes, a power of two >= 2.
REQ-004 SHALL have port clk_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port rx_i, input, 1 bit: asynchronous serial line, driven by the HPS UART0 TX (hps_io_hps_io_uart0_inst_TX); idles high.
REQ-007 SHALL have port rx_data, output, 8 bits: head-of-FIFO byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-009 SHALL have port rx_ready, input, 1 bit: consumer accepts the head byte.
REQ-010 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-011 SHALL have ports frame_err, overrun and parity_err, each output, 1 bit: one-cycle error pulses.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-013 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) cycles, truncated; with the defaults DIV = 27, so one bit = 432 cycles.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 In IDLE, a high-to-low transition of the synchronized line SHALL move the FSM to START and clear the tick counter.
REQ-016 In START, at tick 7 (mid-bit) the FSM SHALL move to DATA if the line is 0, otherwise return to IDLE (glitch rejection).
REQ-017 In DATA, the FSM SHALL sample every 16 ticks at mid-bit, shift in LSB first, and after 8 bits move to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-018 In STOP, a sampled 1 SHALL push the byte into the FIFO in the same cycle; rx_valid SHALL go high on the next cycle.
REQ-019 In STOP, a sampled 0 SHALL discard the byte and pulse frame_err for 1 cycle; IDLE SHALL then accept a new start only after the line has been seen high (break tolerance).
REQ-020 The FIFO SHALL be show-ahead: rx_data is valid whenever rx_valid is high, and a pop occurs when rx_valid && rx_ready.
REQ-021 A push when full with no simultaneous pop SHALL drop the new byte, pulse overrun for 1 cycle, and leave FIFO contents unchanged.
REQ-022 A simultaneous push and pop when full SHALL succeed with no overrun; a simultaneous push and pop when empty SHALL leave level 1 after the push.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range 0..FIFO_DEPTH.

Reset
REQ-024 On reset_reset, the FSM SHALL go to IDLE and the tick/bit counters, FIFO pointers and fifo_level SHALL clear to 0.
REQ-025 On reset, rx_valid, frame_err, overrun and parity_err SHALL be 0, and the synchronizer flops SHALL be set to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; reception SHALL restart only on the next falling edge after the line has been seen high.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, frames SHALL be 8E1: the PARITY state samples a bit, and an even-parity mismatch SHALL discard the byte and pulse parity_err for 1 cycle; the STOP state is still checked.
REQ-028 Without UART_RX_PARITY_EN, frames SHALL be 8N1, the PARITY state SHALL be unreachable, and parity_err SHALL be tied to 0.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state enum, the OVERSAMPLE=16 constant and the midpoint tick constant 7.
REQ-030 The FIFO SHALL be a separate sub-module uart_rx_fifo (parameterised depth, synchronous, show-ahead); the FSM, tick generator and synchronizer SHALL stay in uart_rx.

Verification (defaults, bit = 432 cycles)
REQ-031 The bench SHALL drive 8N1 byte 0xA5 with rx_ready=1 and check rx_data=0xA5, rx_valid high 1 cycle after the stop-bit sample, and frame_err=0.
REQ-032 The bench SHALL drive rx_i low for 100 cycles then high and check that no byte is pushed, fifo_level=0 and the FSM returns to IDLE.
REQ-033 The bench SHALL drive byte 0x3C with stop bit 0 and check one frame_err pulse, fifo_level unchanged, and that the next valid frame 0x3D is received.
REQ-034 The bench SHALL hold rx_ready=0, send 0x01..0x09, and check fifo_level=8 and an overrun pulse on the 9th byte; it SHALL then pop and check output 0x01..0x08 in order.
REQ-035 The bench SHALL assert reset_reset during data bit 4 of a frame and check all outputs are at reset values; after release it SHALL send 0x5A and check it is received intact.
REQ-036 With UART_RX_PARITY_EN, the bench SHALL send 0x07 with parity bit 0 and check a parity_err pulse and no push; it SHALL then send 0x07 with parity bit 1 and check rx_data=0x07.
